// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - sequencer for a single-MAC neuron: load inputs, clear, accumulate, deliver per channel
module neuron_seq_ctrl #(
  parameter  int DEPTH   = 64,
  parameter  int OUT_LAT = 2,
  parameter  int NUM_CH  = 1,
  localparam int PTR_W   = (DEPTH  <= 2) ? 1 : $clog2(DEPTH),
  localparam int CH_W    = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chip_sel,
  input  logic             wr_en,
  input  logic             threshold_ready,
  input  logic             out_ack,
  output logic             rst_mem,
  output logic             mul_mem_en,
  output logic             ac_mem_en,
  output logic [PTR_W-1:0] wr_data_ptr,
  output logic [PTR_W-1:0] rd_data_ptr,
  output logic [CH_W-1:0]  ch_idx,
  output logic             output_ready,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  localparam int CNT_W = (OUT_LAT <= 2) ? 1 : $clog2(OUT_LAT);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_LAT - 1);

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    WRITE_DATA      = 3'd1,
    WRITE_THRESHOLD = 3'd2,
    CLEAR           = 3'd3,
    COMPUTE         = 3'd4,
    WAIT_OUTPUT     = 3'd5,
    READ_OUTPUT     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    // Deselect wins over every transition, including the final acknowledge.
    if (state_q != IDLE && !chip_sel) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ch_d     = '0;
      cnt_d    = '0;
      abort_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (chip_sel && wr_en) begin
            state_d  = WRITE_DATA;
            wr_ptr_d = '0;
          end
        end
        WRITE_DATA: begin
          if (wr_en) begin
            if (wr_ptr_q == PTR_LAST) begin
              wr_ptr_d = '0;
              state_d  = WRITE_THRESHOLD;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
        WRITE_THRESHOLD: begin
          if (threshold_ready) state_d = CLEAR;
        end
        CLEAR: begin
          rd_ptr_d = '0;
          state_d  = COMPUTE;
        end
        COMPUTE: begin
          if (rd_ptr_q == PTR_LAST) begin
            rd_ptr_d = '0;
            cnt_d    = '0;
            state_d  = WAIT_OUTPUT;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
        WAIT_OUTPUT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = READ_OUTPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        READ_OUTPUT: begin
          if (out_ack) begin
            if (ch_q == CH_LAST) begin
              ch_d    = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = CLEAR;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rst_mem      = 1'b0;
    mul_mem_en   = 1'b0;
    ac_mem_en    = 1'b0;
    output_ready = 1'b0;
    busy         = (state_q != IDLE);
    wr_data_ptr  = wr_ptr_q;
    rd_data_ptr  = rd_ptr_q;
    ch_idx       = ch_q;
    done         = done_q;
    abort        = abort_q;
    case (state_q)
      CLEAR:       rst_mem = 1'b1;
      COMPUTE: begin
        mul_mem_en = 1'b1;
        ac_mem_en  = 1'b1;
      end
      READ_OUTPUT: output_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb/tb_neuron_seq_ctrl.sv - directed bench for neuron_seq_ctrl (DEPTH=8, OUT_LAT=2, NUM_CH=3)
module tb_neuron_seq_ctrl;

  localparam int DEPTH   = 8;
  localparam int OUT_LAT = 2;
  localparam int NUM_CH  = 3;

  logic       clk = 1'b0;
  logic       rst, chip_sel, wr_en, threshold_ready, out_ack;
  logic       rst_mem, mul_mem_en, ac_mem_en, output_ready, busy, done, abort;
  logic [2:0] wr_data_ptr, rd_data_ptr;
  logic [1:0] ch_idx;

  int tests = 0;
  int fails = 0;

  neuron_seq_ctrl #(.DEPTH(DEPTH), .OUT_LAT(OUT_LAT), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .chip_sel(chip_sel), .wr_en(wr_en),
    .threshold_ready(threshold_ready), .out_ack(out_ack),
    .rst_mem(rst_mem), .mul_mem_en(mul_mem_en), .ac_mem_en(ac_mem_en),
    .wr_data_ptr(wr_data_ptr), .rd_data_ptr(rd_data_ptr), .ch_idx(ch_idx),
    .output_ready(output_ready), .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  // {rst_mem, mul_mem_en, ac_mem_en, output_ready, busy, done, abort}
  function automatic logic [6:0] flags();
    return {rst_mem, mul_mem_en, ac_mem_en, output_ready, busy, done, abort};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_words();
    // Entry cycle from IDLE, then DEPTH accepted words in WRITE_DATA.
    chip_sel = 1'b1;
    wr_en    = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      chk("wr_ptr_seq", 32'(wr_data_ptr), i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; chip_sel = 1'b0; wr_en = 1'b0; threshold_ready = 1'b0; out_ack = 1'b0;
    tick();
    tick();
    chk("reset_flags", 32'(flags()), 0);
    chk("reset_wr_ptr", 32'(wr_data_ptr), 0);
    chk("reset_ch", 32'(ch_idx), 0);
    rst = 1'b0;

    wr_en = 1'b1;
    tick();
    chk("idle_wr_no_sel", 32'(busy), 0);

    // Full three-channel run with contiguous writes.
    load_words();
    chk("wt_ptr_wrap", 32'(wr_data_ptr), 0);
    chk("wt_flags", 32'(flags()), 32'(7'b0000100));
    out_ack = 1'b1;
    tick();
    tick();
    out_ack = 1'b0;
    chk("wt_hold", 32'(flags()), 32'(7'b0000100));
    threshold_ready = 1'b1;
    tick();
    threshold_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("clear_flags", 32'(flags()), 32'(7'b1000100));
      chk("ch_idx", 32'(ch_idx), c);
      tick();
      for (int k = 0; k < DEPTH; k++) begin
        chk("compute_flags", 32'(flags()), 32'(7'b0110100));
        chk("rd_ptr_seq", 32'(rd_data_ptr), k);
        tick();
      end
      for (int w = 0; w < OUT_LAT; w++) begin
        chk("wait_flags", 32'(flags()), 32'(7'b0000100));
        tick();
      end
      chk("read_flags", 32'(flags()), 32'(7'b0001100));
      tick();
      chk("read_hold", 32'(flags()), 32'(7'b0001100));
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
    end
    chk("done_pulse", 32'(flags()), 32'(7'b0000010));
    chk("done_ch_reset", 32'(ch_idx), 0);
    tick();
    chk("done_clear", 32'(flags()), 0);

    // Gapped writes: 3 words, 2 idle cycles, 5 words.
    chip_sel = 1'b1;
    wr_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    wr_en = 1'b0;
    chk("gap_ptr3", 32'(wr_data_ptr), 3);
    tick();
    tick();
    chk("gap_hold", 32'(wr_data_ptr), 3);
    threshold_ready = 1'b1;
    tick();
    chk("gap_no_thresh", 32'(rst_mem), 0);
    threshold_ready = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("gap_ptr7", 32'(wr_data_ptr), 7);
    tick();
    wr_en = 1'b0;
    chk("gap_wrap", 32'(wr_data_ptr), 0);
    threshold_ready = 1'b1;
    tick();
    threshold_ready = 1'b0;
    chk("gap_clear", 32'(flags()), 32'(7'b1000100));

    // Abort mid-COMPUTE at rd_ptr 4.
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("abort_at_rd4", 32'(rd_data_ptr), 4);
    chip_sel = 1'b0;
    tick();
    chk("abort_flags", 32'(flags()), 32'(7'b0000001));
    chk("abort_rd_ptr", 32'(rd_data_ptr), 0);
    tick();
    chk("abort_clear", 32'(flags()), 0);

    // Reset during WAIT_OUTPUT, then a fresh transaction.
    load_words();
    threshold_ready = 1'b1;
    tick();
    threshold_ready = 1'b0;
    for (int k = 0; k <= DEPTH; k++) tick();
    chk("pre_rst_wait", 32'(flags()), 32'(7'b0000100));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_flags", 32'(flags()), 0);
    chk("rst_ptrs", 32'({wr_data_ptr, rd_data_ptr, ch_idx}), 0);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_ptr", 32'(wr_data_ptr), 0);
    chk("restart_ch", 32'(ch_idx), 0);
    chip_sel = 1'b0;
    tick();
    chk("abort_in_write", 32'(flags()), 32'(7'b0000001));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
